// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for register_file_param and register_nb:
//   - NO_ZERO_REG : ZERO_REG value meaning "no hardwired-zero register"
//   - calc_aw()   : address width for a given DEPTH, max(1, clog2(DEPTH))
//   - byte_merge(): byte-wise merge of an old and a new word under a byte mask
package regfile_pkg;

   localparam int NO_ZERO_REG = -1;

   // byte_merge works on the widest supported word; callers zero-extend
   // their operands and truncate the result back to their own WIDTH.
   localparam int MAX_W  = 256;
   localparam int MAX_BE = MAX_W / 8;

   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [MAX_W-1:0] byte_merge(
      input logic [MAX_W-1:0]  old_w,
      input logic [MAX_W-1:0]  new_w,
      input logic [MAX_BE-1:0] be_w
   );
      logic [MAX_W-1:0] m;
      m = old_w;
      for (int unsigned i = 0; i < MAX_BE; i++)
         if (be_w[i]) m[8*i +: 8] = new_w[8*i +: 8];
      return m;
   endfunction

endpackage

// File: rtl/register_file_param_nb.sv
// register_nb
//   WIDTH-bit register with per-byte load enables and a synchronous,
//   active-low clear that takes priority over loading.
//   Ports:
//     clk   in  1        clock, rising edge
//     clr   in  1        synchronous clear, active-low
//     i_le  in  WIDTH/8  per-byte load enables
//     i_d   in  WIDTH    load data
//     o_q   out WIDTH    register contents
module register_nb
   import regfile_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [WIDTH/8-1:0] i_le,
   input  logic [WIDTH-1:0]   i_d,
   output logic [WIDTH-1:0]   o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_q <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH / 8; i++)
            if (i_le[i]) r_q[8*i +: 8] <= i_d[8*i +: 8];
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/register_file_param.sv
// register_file_param
//   DEPTH x WIDTH register file: one byte-maskable write port, three
//   combinational read ports, optional hardwired-zero register and optional
//   same-cycle write-to-read bypass.
//   Ports:
//     clk      in  1        clock, rising edge
//     clr      in  1        synchronous clear, active-low, beats le
//     le       in  1        write enable
//     wa       in  AW       write address
//     wd       in  WIDTH    write data
//     be       in  WIDTH/8  write byte enables
//     ra/rb/rc in  AW       read addresses
//     qa/qb/qc out WIDTH    read data
//     wr_done  out 1        one-cycle pulse after each effective write
module register_file_param
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 16,
   parameter  int ZERO_REG = NO_ZERO_REG,
   parameter  int BYPASS   = 1,
   localparam int AW       = calc_aw(DEPTH),
   localparam int NB       = WIDTH / 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             le,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [NB-1:0]    be,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   output logic [WIDTH-1:0] qa,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] qc,
   output logic             wr_done
);

   logic [WIDTH-1:0] w_q [DEPTH];
   logic             w_wr_eff;
   logic [WIDTH-1:0] w_old;
   logic [WIDTH-1:0] w_merged;
   logic [AW-1:0]    w_raddr [3];
   logic [WIDTH-1:0] w_rdata [3];
   logic             r_wr_done;

   // Address maps onto a real, writable/readable register.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
   endfunction

   assign w_wr_eff = clr & le & (|be) & addr_live(wa);

   for (genvar k = 0; k < DEPTH; k++) begin : g_reg
      logic [NB-1:0] w_le;
      assign w_le = (w_wr_eff && (wa == AW'(k))) ? be : '0;
      register_nb #(.WIDTH(WIDTH)) u_reg (
         .clk  (clk),
         .clr  (clr),
         .i_le (w_le),
         .i_d  (wd),
         .o_q  (w_q[k])
      );
   end

   always_comb begin
      w_old = '0;
      for (int unsigned k = 0; k < DEPTH; k++)
         if (wa == AW'(k)) w_old = w_q[k];
   end

   assign w_merged = WIDTH'(byte_merge(MAX_W'(w_old), MAX_W'(wd), MAX_BE'(be)));

   assign w_raddr[0] = ra;
   assign w_raddr[1] = rb;
   assign w_raddr[2] = rc;

   // w_wr_eff already excludes clr=0, empty be, out-of-range and ZERO_REG,
   // so a bypass hit can only ever forward a write that really lands.
   always_comb begin
      for (int unsigned p = 0; p < 3; p++) begin
         w_rdata[p] = '0;
         if ((BYPASS != 0) && w_wr_eff && (w_raddr[p] == wa)) begin
            w_rdata[p] = w_merged;
         end else if (addr_live(w_raddr[p])) begin
            for (int unsigned k = 0; k < DEPTH; k++)
               if (w_raddr[p] == AW'(k)) w_rdata[p] = w_q[k];
         end
      end
   end

   assign qa = w_rdata[0];
   assign qb = w_rdata[1];
   assign qc = w_rdata[2];

   always_ff @(posedge clk) begin
      if (!clr) r_wr_done <= 1'b0;
      else      r_wr_done <= w_wr_eff;
   end

   assign wr_done = r_wr_done;

endmodule

// File: tb/tb_register_file_param.sv
// Testbench for register_file_param: default build, BYPASS=0 build and a
// ZERO_REG=0/DEPTH=12 build share one stimulus; a WIDTH=16/DEPTH=8 build is
// exercised with random traffic against a reference model.
module tb_register_file_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus for u0/u1/u2 (AW=4, WIDTH=32)
   logic        clr, le;
   logic [3:0]  wa, be, ra, rb, rc;
   logic [31:0] wd;
   logic [31:0] qa0, qb0, qc0, qa1, qb1, qc1, qa2, qb2, qc2;
   logic        wrd0, wrd1, wrd2;

   // u3 (WIDTH=16, DEPTH=8, AW=3)
   logic        clr3, le3;
   logic [2:0]  wa3, ra3, rb3, rc3;
   logic [15:0] wd3, qa3, qb3, qc3;
   logic [1:0]  be3;
   logic        wrd3;

   register_file_param u0 (
      .clk(clk), .clr(clr), .le(le), .wa(wa), .wd(wd), .be(be),
      .ra(ra), .rb(rb), .rc(rc), .qa(qa0), .qb(qb0), .qc(qc0), .wr_done(wrd0));

   register_file_param #(.BYPASS(0)) u1 (
      .clk(clk), .clr(clr), .le(le), .wa(wa), .wd(wd), .be(be),
      .ra(ra), .rb(rb), .rc(rc), .qa(qa1), .qb(qb1), .qc(qc1), .wr_done(wrd1));

   register_file_param #(.WIDTH(32), .DEPTH(12), .ZERO_REG(0), .BYPASS(1)) u2 (
      .clk(clk), .clr(clr), .le(le), .wa(wa), .wd(wd), .be(be),
      .ra(ra), .rb(rb), .rc(rc), .qa(qa2), .qb(qb2), .qc(qc2), .wr_done(wrd2));

   register_file_param #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u3 (
      .clk(clk), .clr(clr3), .le(le3), .wa(wa3), .wd(wd3), .be(be3),
      .ra(ra3), .rb(rb3), .rc(rc3), .qa(qa3), .qb(qb3), .qc(qc3), .wr_done(wrd3));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic l, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [3:0] x, input logic [3:0] y, input logic [3:0] z);
      clr = c; le = l; wa = a; wd = d; be = b; ra = x; rb = y; rc = z;
   endtask

   typedef struct {
      logic        c, l;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  b, x, y, z;
      logic [31:0] eqa, eqb, eqc;
      logic        ewd;
   } vec_t;
   vec_t tv [12];

   // reference model for u3
   logic [15:0] m [8];
   logic        mwd;
   logic        hit;
   logic [15:0] mask, nv;

   function automatic logic [15:0] exp_rd(input logic [2:0] r);
      return (hit && (r == wa3)) ? nv : m[r];
   endfunction

   initial begin
      drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 4'd0);
      clr3 = 1'b1; le3 = 1'b0; wa3 = '0; wd3 = '0; be3 = '0; ra3 = '0; rb3 = '0; rc3 = '0;

      // inputs are applied at the falling edge, outputs checked 2 time units later
      tv[0]  = '{1'b1, 1'b1, 4'd3,  32'h11223344, 4'hF, 4'd3,  4'd4,  4'd3,  32'h11223344, 32'h0,        32'h11223344, 1'b0};
      tv[1]  = '{1'b1, 1'b1, 4'd3,  32'hAABBCCDD, 4'h5, 4'd3,  4'd3,  4'd0,  32'h11BB33DD, 32'h11BB33DD, 32'h0,        1'b1};
      tv[2]  = '{1'b1, 1'b0, 4'd3,  32'hFFFFFFFF, 4'hF, 4'd3,  4'd3,  4'd3,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1};
      tv[3]  = '{1'b1, 1'b1, 4'd3,  32'h00000000, 4'h0, 4'd3,  4'd3,  4'd3,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0};
      tv[4]  = '{1'b1, 1'b0, 4'd3,  32'h00000000, 4'h0, 4'd3,  4'd0,  4'd15, 32'h11BB33DD, 32'h0,        32'h0,        1'b0};
      tv[5]  = '{1'b1, 1'b1, 4'd5,  32'h00000001, 4'hF, 4'd3,  4'd5,  4'd6,  32'h11BB33DD, 32'h00000001, 32'h0,        1'b0};
      tv[6]  = '{1'b1, 1'b1, 4'd6,  32'h12345678, 4'h8, 4'd5,  4'd6,  4'd6,  32'h00000001, 32'h12000000, 32'h12000000, 1'b1};
      tv[7]  = '{1'b1, 1'b1, 4'd15, 32'hCAFEBABE, 4'hF, 4'd15, 4'd6,  4'd5,  32'hCAFEBABE, 32'h12000000, 32'h00000001, 1'b1};
      tv[8]  = '{1'b0, 1'b1, 4'd2,  32'hFFFFFFFF, 4'hF, 4'd2,  4'd15, 4'd5,  32'h0,        32'hCAFEBABE, 32'h00000001, 1'b1};
      tv[9]  = '{1'b1, 1'b1, 4'd2,  32'hFFFFFFFF, 4'hF, 4'd2,  4'd15, 4'd5,  32'hFFFFFFFF, 32'h0,        32'h0,        1'b0};
      tv[10] = '{1'b1, 1'b0, 4'd2,  32'h00000000, 4'h0, 4'd2,  4'd3,  4'd15, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
      tv[11] = '{1'b1, 1'b0, 4'd2,  32'h00000000, 4'h0, 4'd2,  4'd1,  4'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        1'b0};

      // ---- reset: fill every register, then one clearing edge
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 4'(i), 32'hA5A5A5A5, 4'hF, 4'd0, 4'd0, 4'd0);
      end
      @(negedge clk);
      drive(1'b0, 1'b1, 4'd0, 32'h12345678, 4'hF, 4'd0, 4'd7, 4'd15);
      #2;
      chk("clr_suppresses_bypass qa", qa0, 32'hA5A5A5A5);
      chk("pre_clear qb", qb0, 32'hA5A5A5A5);
      chk("pre_clear qc", qc0, 32'hA5A5A5A5);
      chk("pre_clear wr_done", {31'b0, wrd0}, 32'h1);
      chk("pre_clear nobyp qa", qa1, 32'hA5A5A5A5);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 4'(i), 4'(15 - i), 4'(i));
         #2;
         chk($sformatf("reset qa[%0d]", i), qa0, 32'h0);
         chk($sformatf("reset qb[%0d]", 15 - i), qb0, 32'h0);
         chk($sformatf("reset qc[%0d]", i), qc0, 32'h0);
         chk($sformatf("reset nobyp qa[%0d]", i), qa1, 32'h0);
         if (i == 0) begin
            chk("reset wr_done", {31'b0, wrd0}, 32'h0);
            chk("reset nobyp wr_done", {31'b0, wrd1}, 32'h0);
         end
      end

      // ---- table-driven vectors on the default build
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(tv[i].c, tv[i].l, tv[i].a, tv[i].d, tv[i].b, tv[i].x, tv[i].y, tv[i].z);
         #2;
         chk($sformatf("v%0d qa", i), qa0, tv[i].eqa);
         chk($sformatf("v%0d qb", i), qb0, tv[i].eqb);
         chk($sformatf("v%0d qc", i), qc0, tv[i].eqc);
         chk($sformatf("v%0d wr_done", i), {31'b0, wrd0}, {31'b0, tv[i].ewd});
      end

      // ---- bypass vs no bypass
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd5, 32'h00000001, 4'hF, 4'd5, 4'd5, 4'd4);
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd5, 32'h000000A0, 4'hF, 4'd5, 4'd5, 4'd4);
      #2;
      chk("byp qa", qa0, 32'h000000A0);
      chk("byp qb", qb0, 32'h000000A0);
      chk("byp qc", qc0, 32'h0);
      chk("nobyp qa pre", qa1, 32'h00000001);
      chk("nobyp qb pre", qb1, 32'h00000001);
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 4'd5, 4'd5, 4'd4);
      #2;
      chk("nobyp qa post", qa1, 32'h000000A0);
      chk("nobyp qb post", qb1, 32'h000000A0);
      chk("byp qa post", qa0, 32'h000000A0);

      // ---- zero register and out-of-range write on the DEPTH=12 build
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd0, 32'hDEADBEEF, 4'hF, 4'd0, 4'd13, 4'd2);
      #2;
      chk("zr bypass qa", qa2, 32'h0);
      chk("zr oor qb", qb2, 32'h0);
      chk("zr reg2 qc", qc2, 32'hFFFFFFFF);
      chk("zr wr_done idle", {31'b0, wrd2}, 32'h0);
      chk("u0 bypass reg0", qa0, 32'hDEADBEEF);
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd13, 32'hDEADBEEF, 4'hF, 4'd0, 4'd13, 4'd5);
      #2;
      chk("zr wr_done after reg0 write", {31'b0, wrd2}, 32'h0);
      chk("zr reg0 read", qa2, 32'h0);
      chk("zr oor bypass", qb2, 32'h0);
      chk("zr reg5", qc2, 32'h000000A0);
      chk("u0 reg0 written", qa0, 32'hDEADBEEF);
      chk("u0 bypass reg13", qb0, 32'hDEADBEEF);
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 4'd13, 4'd0, 4'd0);
      #2;
      chk("zr wr_done after oor write", {31'b0, wrd2}, 32'h0);
      chk("u0 reg13 written", qa0, 32'hDEADBEEF);
      for (int i = 0; i < 16; i++) begin
         logic [31:0] e;
         e = (i == 2) ? 32'hFFFFFFFF : (i == 5) ? 32'h000000A0 : 32'h0;
         ra = 4'(i);
         #1;
         chk($sformatf("zr sweep q[%0d]", i), qa2, e);
      end

      // ---- WIDTH=16 random traffic against the model
      @(negedge clk);
      clr3 = 1'b0; le3 = 1'b0;
      for (int k = 0; k < 8; k++) m[k] = '0;
      mwd = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         clr3 = ($urandom_range(0, 15) != 0);
         le3  = ($urandom_range(0, 3) != 0);
         wa3  = 3'($urandom_range(0, 7));
         wd3  = 16'($urandom);
         be3  = 2'($urandom_range(0, 3));
         ra3  = 3'($urandom_range(0, 7));
         rb3  = ($urandom_range(0, 1) != 0) ? wa3 : 3'($urandom_range(0, 7));
         rc3  = wa3;
         #2;
         mask = {{8{be3[1]}}, {8{be3[0]}}};
         nv   = (m[wa3] & ~mask) | (wd3 & mask);
         hit  = clr3 && le3 && (be3 != 2'b00);
         chk($sformatf("w16 c%0d qa", n), {16'b0, qa3}, {16'b0, exp_rd(ra3)});
         chk($sformatf("w16 c%0d qb", n), {16'b0, qb3}, {16'b0, exp_rd(rb3)});
         chk($sformatf("w16 c%0d qc", n), {16'b0, qc3}, {16'b0, exp_rd(rc3)});
         chk($sformatf("w16 c%0d wr_done", n), {31'b0, wrd3}, {31'b0, mwd});
         if (!clr3) begin
            for (int k = 0; k < 8; k++) m[k] = '0;
            mwd = 1'b0;
         end else if (hit) begin
            m[wa3] = nv;
            mwd = 1'b1;
         end else begin
            mwd = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised multi-port register file for the processor datapath. It is the successor to the single 32-bit load-enable register: DEPTH registers of WIDTH bits, one byte-maskable write port, three asynchronous read ports, an optional hardwired-zero register and optional write-to-read bypass. It sits between the decode stage, which drives the read addresses, and the writeback stage, which drives the write port.

## Interface
Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- DEPTH, 16, number of registers; need not be a power of 2.
- ZERO_REG, -1, index of a register that reads as 0 and ignores writes; -1 disables this.
- BYPASS, 1, when 1, a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous and active-low. Clears every register on the next rising edge of clk.
- le  in  1  write (load) enable, active-high.
- wa  in  AW  write address, where AW = max(1, clog2(DEPTH)).
- wd  in  WIDTH  write data.
- be  in  WIDTH/8  byte enables for the write; be[i] covers wd[8i+7:8i].
- ra, rb, rc  in  AW each  read addresses.
- qa, qb, qc  out  WIDTH each  read data for ra, rb and rc.
- wr_done  out  1  registered pulse; set for one cycle after an effective write.

## Operation
- **Reset:** clr=0 sampled at a clk edge sets all registers to 0 and sets wr_done to 0. clr has priority over le. clr=0 held for several cycles keeps the registers at 0.
- **Write:** when clr=1 and le=1 at a clk edge, for each i with be[i]=1, register[wa] byte i takes wd byte i. Bytes with be[i]=0 keep their value.
- **Ignored writes:** the write has no effect if:
  - be is all zeros,
  - wa is at or above DEPTH, or
  - wa equals ZERO_REG.
- **wr_done:** set to 1 on the edge after an effective write; 0 otherwise, including after ignored writes.
- **Reads:** combinational.
  - qx = register[rx].
  - qx = 0 if rx is at or above DEPTH, or if rx equals ZERO_REG.
- **Bypass (BYPASS=1):** if le=1, clr=1 and rx equals wa for an effective write, qx = the merged value. The merged value takes byte i from wd where be[i]=1 and from register[wa] otherwise. All three ports bypass independently, and several ports may match the same wa.
- **No bypass (BYPASS=0):** reads return the pre-edge contents until the write edge.
- **Reset vs. bypass:** clr=0 suppresses bypass. Reads show the current register contents until the clearing edge, and 0 after it.

## Timing
- Write latency is one edge. The new value is visible on non-bypassed reads immediately after the edge.
- Read latency is zero cycles (combinational from the address and, with bypass, from wd, be and le).
- wr_done rises 1 cycle after the write edge and lasts exactly 1 cycle per write. With back-to-back writes it stays high.
- Reset value of every output: qa, qb and qc = 0 for all addresses after one clr=0 edge; wr_done = 0.
- Simultaneous events:
  - clr=0 with le=1: the clear wins and no write happens.
  - A read of wa in the same cycle as the write follows the bypass rule.
- Reset mid-write-burst: writes stop on the first clr=0 edge and resume on the first edge with clr=1 and le=1.

## Structure
- Shared package regfile_pkg contains:
  - a function computing AW from DEPTH,
  - a byte-merge function (old, new, be) returning the merged word,
  - the constant NO_ZERO_REG = -1.
- Sub-module register_nb, instantiated DEPTH times via generate. It is a parametrised WIDTH-bit register with:
  - clk, clr (synchronous, active-low), per-byte load enables, D and Q.
- The top level holds:
  - write address decode, gated with le, the ignore conditions and be,
  - three read muxes with out-of-range/ZERO_REG forcing and bypass,
  - the wr_done flop.

## Test plan
- **Reset:** write 0xA5A5A5A5 to all 16 registers, then hold clr=0 for 1 edge → qa, qb and qc = 0 for every address; wr_done = 0.
- **Byte masking:** write 0x11223344 to reg 3 with be=1111, then wd=0xAABBCCDD with be=0101 → reg 3 = 0x11BB33DD; wr_done pulses once per write.
- **Bypass:** with BYPASS=1, reg 5 = 0x00000001, and le=1, wa=5, wd=0x000000A0, be=1111, ra=rb=5 in the same cycle → qa = qb = 0x000000A0 before the edge. The same test with BYPASS=0 → 0x00000001 before the edge and 0x000000A0 after it.
- **Zero register and range:** with ZERO_REG=0 and DEPTH=12, writes to reg 0 and to address 13 → reads of both return 0; wr_done stays 0; no other register changes.
- **Reset priority:** clr=0 with le=1, wa=2, wd=0xFFFFFFFF → reg 2 = 0. Then clr=1 the next cycle with the same write → reg 2 = 0xFFFFFFFF.
- **Width sweep:** WIDTH=16, DEPTH=8 → byte-mask and bypass results match a reference model over 1000 random cycles.
